// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
// Magnitudes are computed over WIDTH cycles; signs are restored in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               div_zero;
  logic               q_neg;
  logic               r_neg;

  logic               is_signed;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_signed = (md_op == 3'd0) || (md_op == 3'd2);
  assign mag1      = (is_signed && num1[WIDTH-1]) ? -num1 : num1;
  assign mag2      = (is_signed && num2[WIDTH-1]) ? -num2 : num2;

  // Multiply: acc = {partial_hi, remaining multiplier bits}, LSB-first shift-add.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : {WIDTH{1'b0}})};
  assign mul_next = {add_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits shifting into quotient bits}.
  assign shifted  = acc[2*WIDTH-1:WIDTH-1];
  assign diff     = shifted - {1'b0, opa};
  assign div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

  // Divide by zero leaves remainder = |num1| with r_neg = num1 MSB, so hi returns num1 as issued.
  assign prod_fix = q_neg ? -acc : acc;
  assign quo_fix  = div_zero ? {WIDTH{1'b1}}
                             : (q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opa      <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              case (md_op)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  is_div   <= md_op[1];
                  div_zero <= md_op[1] && (num2 == '0);
                  q_neg    <= is_signed && (num1[WIDTH-1] ^ num2[WIDTH-1]);
                  r_neg    <= is_signed && md_op[1] && num1[WIDTH-1];
                  opa      <= md_op[1] ? mag2 : mag1;
                  acc      <= {{WIDTH{1'b0}}, (md_op[1] ? mag1 : mag2)};
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
                end
                3'd4:    hi <= num1;
                3'd5:    lo <= num1;
                default: ;
              endcase
            end
          end
          CALC: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit (WIDTH=32 and WIDTH=8)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd7;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  md_op8 = 3'd7;
  logic [7:0]  num1_8 = '0;
  logic [7:0]  num2_8 = '0;
  logic        flush8 = 1'b0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .num1(num1), .num2(num2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .md_op(md_op8), .num1(num1_8), .num2(num2_8),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Issue at a negedge; returns at the negedge where done is seen (or timeout).
  // lat counts clock edges from the start-sampling edge through the done edge.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    start = 1'b1; md_op = op; num1 = a; num2 = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0; num1 = $urandom; num2 = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk); lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    start8 = 1'b1; md_op8 = op; num1_8 = a; num2_8 = b;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < 100) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
    vectors++; if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_multu_max();
    int lat; bit bok;
    run32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL multu_latency got %0d want 34", lat); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL multu_busy_window got %0b want 1", bok); end
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width got %0b want 0", done); end
  endtask

  task automatic test_signed();
    int lat; bit bok;
    run32(3'd0, 32'hFFFF_FFF9, 32'd3, lat, bok);
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_neg_lo got %h want ffffffeb", lo); end
    @(negedge clk);
    run32(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bok);
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    @(negedge clk);
    run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL div_ovf_hi got %h want 0", hi); end
    @(negedge clk);
  endtask

  task automatic test_divu();
    int lat; bit bok;
    run32(3'd3, 32'd100, 32'd7, lat, bok);
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo got %0d want 14", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi got %0d want 2", hi); end
    @(negedge clk);
    run32(3'd3, 32'd5, 32'd0, lat, bok);
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL div0_latency got %0d want 34", lat); end
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL div0_hi got %h want 5", hi); end
    @(negedge clk);
    run32(3'd2, 32'hFFFF_FFF6, 32'd0, lat, bok);
    vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sdiv0_lo got %h want ffffffff", lo); end
    vectors++; if (hi !== 32'hFFFF_FFF6) begin miscompares++; $display("FAIL sdiv0_hi got %h want fffffff6", hi); end
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; md_op = 3'd4; num1 = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL mthi_busy_done got %b want 00", {busy, done}); end
    md_op = 3'd5; num1 = 32'hCAFE_BABE;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    vectors++; if (lo !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL mtlo_lo got %h want cafebabe", lo); end
    vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL mtlo_busy_done got %b want 00", {busy, done}); end
    md_op = 3'd6; num1 = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    vectors++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, 32'hCAFE_BABE}) begin
      miscompares++; $display("FAIL noop_op6 got busy=%0b hi=%h lo=%h want 0/12345678/cafebabe", busy, hi, lo);
    end
  endtask

  task automatic test_flush();
    int lat; bit bok; bit saw_done; bit busy_bad;
    saw_done = 1'b0; busy_bad = 1'b0;
    start = 1'b1; md_op = 3'd0; num1 = 32'd5; num2 = 32'd6;
    @(posedge clk);
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = (c == 5); md_op = (c == 5) ? 3'd3 : 3'd0;
      num1 = 32'd9; num2 = 32'd3;
      flush = (c == 10);
    end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy_bad !== 1'b0) begin miscompares++; $display("FAIL flush_busy_before got %0b want 0", busy_bad); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %0b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL flush_no_done got %0b want 0", saw_done); end
    vectors++; if ({hi, lo} !== {32'h1234_5678, 32'hCAFE_BABE}) begin
      miscompares++; $display("FAIL flush_hilo_kept got %h_%h want 12345678_cafebabe", hi, lo);
    end
    run32(3'd1, 32'd3, 32'd4, lat, bok);
    vectors++; if ({hi, lo} !== {32'd0, 32'd12}) begin miscompares++; $display("FAIL after_flush_multu got %h_%h want 0_c", hi, lo); end
    @(negedge clk);
    // Flush landing on the FIX cycle must suppress the write and the pulse.
    start = 1'b1; md_op = 3'd1; num1 = 32'd7; num2 = 32'd8;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fix_cycle_busy got %0b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    vectors++; if ({busy, done, hi, lo} !== {2'b00, 32'd0, 32'd12}) begin
      miscompares++; $display("FAIL flush_in_fix got b=%0b d=%0b hi=%h lo=%h want 0 0 0 c", busy, done, hi, lo);
    end
    start = 1'b1; md_op = 3'd4; num1 = 32'h5555_AAAA; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; flush = 1'b0;
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL flush_drops_mthi got %h want 0", hi); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; md_op = 3'd4; num1 = 32'hA5A5_0001;
    @(posedge clk); @(negedge clk);
    start = 1'b1; md_op = 3'd1; num1 = 32'd3; num2 = 32'd5;
    @(posedge clk);
    for (int c = 0; c < 6; c++) @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy got %0b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, done, hi, lo} !== 66'h0) begin
      miscompares++; $display("FAIL async_reset got b=%0b d=%0b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_width8();
    int lat;
    run8(3'd1, 8'hFF, 8'hFF, lat);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL w8_latency got %0d want 10", lat); end
    vectors++; if ({hi8, lo8} !== 16'hFE01) begin miscompares++; $display("FAIL w8_multu got %h want fe01", {hi8, lo8}); end
    @(negedge clk);
    run8(3'd3, 8'd200, 8'd9, lat);
    vectors++; if ({hi8, lo8} !== {8'd2, 8'd22}) begin miscompares++; $display("FAIL w8_divu got %h want 0216", {hi8, lo8}); end
    @(negedge clk);
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_multu_max();
    test_signed();
    test_divu();
    test_mthi_mtlo();
    test_flush();
    test_reset_mid();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
